// File: rtl/moore_seq_det_pkg.sv
// Shared constants and depth type for the serial Moore sequence detector.
package moore_seq_det_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

  function automatic int depth_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_DEPTH_W = depth_w(DEF_MAX_LEN);
  typedef logic [DEF_DEPTH_W-1:0] depth_t;
endpackage

// File: rtl/moore_seq_det_cmp.sv
// Next match depth: compares every pattern prefix against the newest history bits in
// parallel, then picks the longest hit no deeper than one past the current depth.
module moore_seq_det_cmp
  import moore_seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int DW      = depth_w(DEF_MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] i_hist,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [DW-1:0]      i_len,
  input  logic [DW-1:0]      i_lim,
  output logic [DW-1:0]      o_k
);
  localparam logic [DW-1:0] LEN_MAX = DW'(MAX_LEN);

  logic [DW-1:0]      w_sh;
  logic [MAX_LEN-1:0] w_al;
  logic [DW:0]        w_lim1;
  logic [DW:0]        w_len_x;
  logic [MAX_LEN:1]   w_hit;

  // Left-align so the first-received pattern bit sits at the MSB for every length.
  assign w_sh    = LEN_MAX - i_len;
  assign w_al    = i_pat << w_sh;
  assign w_lim1  = {1'b0, i_lim} + (DW+1)'(1);
  assign w_len_x = {1'b0, i_len};

  for (genvar j = 1; j <= MAX_LEN; j++) begin : g_pfx
    localparam logic [DW:0] LEN_J = (DW+1)'(j);
    assign w_hit[j] = (i_hist[j-1:0] == w_al[MAX_LEN-1 -: j]) &&
                      (LEN_J <= w_len_x) && (LEN_J <= w_lim1);
  end

  always_comb begin
    o_k = '0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (w_hit[j]) o_k = DW'(j);
    end
  end
endmodule

// File: rtl/moore_seq_det.sv
// Programmable serial pattern detector with registered Moore match output and load checking.
// Optional saturating match counter on o_count when MOORE_SEQ_DET_CNT_EN is defined.
module moore_seq_det
  import moore_seq_det_pkg::*;
#(
  parameter int                 MAX_LEN   = DEF_MAX_LEN,
  parameter logic [MAX_LEN-1:0] RESET_PAT = 8'b1011_0110,
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_d,
  input  logic                         i_valid,
  input  logic                         i_overlap,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  output logic                         o_d,
  output logic                         o_cfg_err
`ifdef MOORE_SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]             o_count
`endif
);
  localparam int            DW      = depth_w(MAX_LEN);
  localparam logic [DW-1:0] LEN_MAX = DW'(MAX_LEN);
  localparam logic [DW-1:0] LEN_MIN = DW'(2);

  logic [MAX_LEN-1:0] r_pat;
  logic [DW-1:0]      r_len;
  logic [DW-1:0]      r_k;
  logic [MAX_LEN-2:0] r_hist;
  logic               r_od;
  logic               r_err;

  logic [MAX_LEN-1:0] w_hist_new;
  logic [DW-1:0]      w_lim;
  logic [DW-1:0]      w_next_k;
  logic               w_len_ok;

  assign w_hist_new = {r_hist, i_d};
  assign w_len_ok   = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
  // Non-overlap exit from MATCH: a depth limit of zero lets only the new bit count.
  assign w_lim      = ((r_k == r_len) && !i_overlap) ? '0 : r_k;

  moore_seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .DW      (DW)
  ) u_cmp (
    .i_hist (w_hist_new),
    .i_pat  (r_pat),
    .i_len  (r_len),
    .i_lim  (w_lim),
    .o_k    (w_next_k)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= RESET_PAT;
      r_len  <= LEN_MAX;
      r_k    <= '0;
      r_hist <= '0;
      r_od   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= cfg_load && !w_len_ok;
      if (cfg_load) begin
        if (w_len_ok) begin
          r_pat  <= cfg_pattern;
          r_len  <= cfg_len;
          r_k    <= '0;
          r_hist <= '0;
          r_od   <= 1'b0;
        end
      end else if (i_valid) begin
        r_k    <= w_next_k;
        r_hist <= w_hist_new[MAX_LEN-2:0];
        r_od   <= (w_next_k == r_len);
      end
    end
  end

  assign o_d       = r_od;
  assign o_cfg_err = r_err;

`ifdef MOORE_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cfg_load) begin
      if (w_len_ok) r_cnt <= '0;
    end else if (i_valid && (w_next_k == r_len) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;
`endif
endmodule
